// File: rtl/serv_dbus_responder_pkg.sv
// Shared constants for the SERV data-bus responder: FSM encoding and bus geometry.
package serv_dbus_responder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 4;

endpackage

// File: rtl/serv_dbus_ram.sv
// Single-port DEPTH x 32 word RAM with per-byte write enables and a registered read.
module serv_dbus_ram
  import serv_dbus_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] we,
  input  logic [AW-1:0]        addr,
  input  logic [31:0]          wdat,
  output logic [31:0]          rdat
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (en) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (we[k]) mem[addr][8*k +: 8] <= wdat[8*k +: 8];
      end
      // Reads only matter for loads; a store cycle never exposes rdat.
      if (we == '0) rdat <= mem[addr];
    end
  end

endmodule

// File: rtl/serv_dbus_responder.sv
// Memory-side responder for the SERV dbus: latency-programmable single-cycle ack
// with byte-lane stores into an internal word RAM.
module serv_dbus_responder
  import serv_dbus_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int AW      = $clog2(DEPTH),
  parameter int LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_we,
  input  logic [31:0]          i_wb_adr,
  input  logic [NUM_LANES-1:0] i_wb_sel,
  input  logic [31:0]          i_wb_dat,
  output logic [31:0]          o_wb_rdt,
  output logic                 o_wb_ack
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic                 ack_q;
  logic                 rdt_vld;
  logic                 go_ack;
  logic [NUM_LANES-1:0] ram_we;
  logic [31:0]          ram_rdat;
  logic [AW-1:0]        word_idx;
  logic                 unused_adr;

  assign word_idx   = i_wb_adr[AW+1:2];
  assign unused_adr = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};

  // go_ack marks the edge entering ACK: the only edge that touches the RAM.
  always_comb begin
    go_ack = 1'b0;
    case (state)
      IDLE:    go_ack = i_wb_cyc && (LAT_M1 == '0);
      WAIT:    go_ack = i_wb_cyc && (cnt == CNT_W'(1));
      default: go_ack = 1'b0;
    endcase
  end

  assign ram_we = (go_ack && i_wb_we) ? i_wb_sel : '0;

  serv_dbus_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk (i_clk),
    .en    (go_ack),
    .we    (ram_we),
    .addr  (word_idx),
    .wdat  (i_wb_dat),
    .rdat  (ram_rdat)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_q   <= 1'b0;
      rdt_vld <= 1'b0;
    end else begin
      ack_q   <= go_ack;
      rdt_vld <= go_ack && !i_wb_we;
      case (state)
        IDLE: begin
          if (i_wb_cyc) begin
            cnt   <= LAT_M1;
            state <= go_ack ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!i_wb_cyc) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // rdt_vld is reset asynchronously, so data vanishes together with ack.
  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_vld ? ram_rdat : '0;

endmodule

// File: tb/tb_serv_dbus_responder.sv
// Directed bench: instance 0 runs LATENCY=1, instance 1 runs LATENCY=4.
module tb_serv_dbus_responder;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        cyc, we, ack;
  logic [1:0][31:0]  adr, dat, rdt;
  logic [1:0][3:0]   sel;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  serv_dbus_responder #(.DEPTH(256), .LATENCY(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc[0]), .i_wb_we(we[0]),
    .i_wb_adr(adr[0]), .i_wb_sel(sel[0]), .i_wb_dat(dat[0]),
    .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]));

  serv_dbus_responder #(.DEPTH(256), .LATENCY(4)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc[1]), .i_wb_we(we[1]),
    .i_wb_adr(adr[1]), .i_wb_sel(sel[1]), .i_wb_dat(dat[1]),
    .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; expected load data goes through the scoreboard queue.
  task automatic txn(input int idx, input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic [31:0] exp_rdt, input string tag);
    int lat;
    int n;
    bit got;
    bit rdt_leak;
    logic [31:0] e;
    lat = (idx == 0) ? 1 : 4;
    exp_q.push_back(w ? 32'h0 : exp_rdt);
    @(negedge clk);
    cyc[idx] = 1'b1; we[idx] = w; adr[idx] = a; sel[idx] = s; dat[idx] = d;
    n = 0; got = 1'b0; rdt_leak = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[idx] === 1'b1) got = 1'b1;
      else if (rdt[idx] !== 32'h0) rdt_leak = 1'b1;
    end
    e = exp_q.pop_front();
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      chk({tag, "_rdt"}, rdt[idx], e);
    end
    chk({tag, "_rdt_zero_before_ack"}, 32'(rdt_leak), 32'd0);
    cyc[idx] = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_drop"}, 32'(ack[idx]), 32'd0);
    chk({tag, "_rdt_drop"}, rdt[idx], 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks_seen;
    int pos[$];
    bit extra;
    rst_n = 1'b0;
    cyc = '0; we = '0; adr = '0; dat = '0; sel = '0;
    #12;
    chk("reset_ack0", 32'(ack[0]), 32'd0);
    chk("reset_rdt0", rdt[0], 32'h0);
    chk("reset_ack1", 32'(ack[1]), 32'd0);
    chk("reset_rdt1", rdt[1], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // LATENCY=1 basic store/load
    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, "l1_store");
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, "l1_load");

    // Byte lanes
    txn(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, "lane_preload");
    txn(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, "lane_store");
    txn(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, "lane_load");
    txn(0, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 32'h0, "sel0_store");
    txn(0, 1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, "sel0_load");

    // Address aliasing
    txn(0, 1'b1, 32'h00000404, 4'hF, 32'h12345678, 32'h0, "alias_store");
    txn(0, 1'b0, 32'hFFFFF404, 4'hF, 32'h0, 32'h12345678, "alias_load");

    // LATENCY=4 setup
    txn(1, 1'b1, 32'h30, 4'hF, 32'h0, 32'h0, "l4_clear");
    txn(1, 1'b1, 32'h34, 4'hF, 32'h55AA55AA, 32'h0, "l4_store");

    // Abort a store after two cycles
    @(negedge clk);
    cyc[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; sel[1] = 4'hF; dat[1] = 32'hCAFEF00D;
    extra = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ack[1] !== 1'b0) extra = 1'b1;
    end
    cyc[1] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] !== 1'b0) extra = 1'b1;
    end
    chk("abort_no_ack", 32'(extra), 32'd0);
    txn(1, 1'b0, 32'h30, 4'hF, 32'h0, 32'h0, "abort_load");

    // Back-to-back loads with cyc held high
    exp_q.push_back(32'h55AA55AA);
    exp_q.push_back(32'h55AA55AA);
    @(negedge clk);
    cyc[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h34;
    acks_seen = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack[1] === 1'b1) begin
        acks_seen++;
        pos.push_back(c);
        chk("b2b_rdt", rdt[1], (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX);
      end
    end
    cyc[1] = 1'b0;
    exp_q.delete();
    chk("b2b_ack_count", 32'(acks_seen), 32'd2);
    if (pos.size() == 2) begin
      chk("b2b_first_latency", 32'(pos[0]), 32'd4);
      chk("b2b_spacing", 32'(pos[1] - pos[0]), 32'd5);
    end
    repeat (6) @(negedge clk);

    // Reset during the ack cycle
    @(negedge clk);
    cyc[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h10; sel[0] = 4'hF;
    @(negedge clk);
    chk("rst_pre_ack", 32'(ack[0]), 32'd1);
    chk("rst_pre_rdt", rdt[0], 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ack", 32'(ack[0]), 32'd0);
    chk("rst_async_rdt", rdt[0], 32'h0);
    cyc[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, "post_rst_load");
    txn(1, 1'b0, 32'h34, 4'hF, 32'h0, 32'h55AA55AA, "post_rst_l4_load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
